wb_scratch_slave: RTL



---
 rtl/wb_scratch_slave_pkg.sv | 18 +
 rtl/wb_scratch_slave_if.sv | 26 ++
 rtl/wb_resp_pipe.sv | 47 ++++
 rtl/wb_scratch_slave.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_scratch_slave_pkg.sv
// Shared definitions for the Wishbone scratch slave: fill pattern and
// response-code encoding carried through the response delay line.
package wb_scratch_slave_pkg;

    localparam logic [31:0] WB_FILL_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_code_e;

    // Unmapped accesses terminate with err only when the slave is built to flag them.
    function automatic resp_code_e resp_code_for(input logic mapped, input logic err_unmapped);
        return (!mapped && err_unmapped) ? RESP_ERR : RESP_ACK;
    endfunction

endpackage

// File: rtl/wb_scratch_slave_if.sv
// Wishbone B4 pipelined bus bundle between a master and the scratch slave.
interface wb_scratch_slave_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic            i_wb_cyc;
    logic            i_wb_stb;
    logic            i_wb_we;
    logic [AW-1:0]   i_wb_addr;
    logic [DW-1:0]   i_wb_data;
    logic [DW/8-1:0] i_wb_sel;
    logic            o_wb_stall;
    logic            o_wb_ack;
    logic            o_wb_err;
    logic [DW-1:0]   o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-length delay line of {valid, code, data}; stage 0 loads at the
// accepting edge so the response is visible LATENCY cycles after accept.
module wb_resp_pipe
    import wb_scratch_slave_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    input  resp_code_e    in_code_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output resp_code_e    out_code_o,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q [LATENCY];
    resp_code_e    code_q  [LATENCY];
    logic [DW-1:0] data_q  [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                code_q[i]  <= RESP_NONE;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            code_q[0]  <= in_code_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                code_q[i]  <= code_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_code_o  = code_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/wb_scratch_slave.sv
// Wishbone B4 pipelined scratch-register slave with byte-lane writes,
// fixed response latency and a bounded number of outstanding requests.
module wb_scratch_slave
    import wb_scratch_slave_pkg::*;
#(
    parameter int          AW           = 8,
    parameter int          DW           = 32,
    parameter int          NREGS        = 16,
    parameter int          LATENCY      = 1,
    parameter int          MAX_OUTST    = 1,
    parameter bit          ERR_UNMAPPED = 1'b0,
    parameter logic [31:0] FILL_DATA    = WB_FILL_PATTERN
) (
    input  logic                i_clk,
    input  logic                i_rst,
    wb_scratch_slave_if.slave   wb
);

    localparam int NB = DW / 8;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [DW-1:0]    regs_q [NREGS];
    logic [CW-1:0]    outst_q, outst_d;
    logic [DW-1:0]    hold_q, hold_d;

    logic             stall;
    logic             accept;
    logic             mapped;
    logic             wr_acc;
    logic [DW-1:0]    lane_mask;
    logic [NREGS-1:0] reg_hit;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    resp_data;
    resp_code_e       resp_code;

    logic             out_valid;
    resp_code_e       out_code;
    logic [DW-1:0]    out_data;

    assign stall  = (outst_q == CW'(MAX_OUTST));
    assign accept = wb.i_wb_cyc && wb.i_wb_stb && !stall;
    assign mapped = ({1'b0, wb.i_wb_addr} < (AW+1)'(NREGS));
    assign wr_acc = accept && wb.i_wb_we && mapped;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wb.i_wb_sel[gi]}};
        end
        for (gi = 0; gi < NREGS; gi++) begin : g_hit
            assign reg_hit[gi] = wr_acc && (wb.i_wb_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_hit[i]) begin
                    regs_q[i] <= (regs_q[i] & ~lane_mask) | (wb.i_wb_data & lane_mask);
                end
            end
        end
    end

    // Addresses beyond the register file match no entry and fall through to the fill pattern.
    always_comb begin
        rd_word = DW'(FILL_DATA);
        for (int i = 0; i < NREGS; i++) begin
            if (wb.i_wb_addr == AW'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    assign resp_data = wb.i_wb_we ? '0 : rd_word;
    assign resp_code = resp_code_for(mapped, ERR_UNMAPPED);

    wb_resp_pipe #(
        .LATENCY (LATENCY),
        .DW      (DW)
    ) u_resp_pipe (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .flush_i     (!wb.i_wb_cyc),
        .in_valid_i  (accept),
        .in_code_i   (resp_code),
        .in_data_i   (resp_data),
        .out_valid_o (out_valid),
        .out_code_o  (out_code),
        .out_data_o  (out_data)
    );

    // Dropping cyc abandons everything in flight, so the count restarts from zero.
    always_comb begin
        outst_d = outst_q;
        if (!wb.i_wb_cyc) begin
            outst_d = '0;
        end else begin
            case ({accept, out_valid})
                2'b10:   outst_d = outst_q + CW'(1);
                2'b01:   outst_d = outst_q - CW'(1);
                default: outst_d = outst_q;
            endcase
        end
    end

    assign hold_d = out_valid ? out_data : hold_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outst_q <= '0;
            hold_q  <= '0;
        end else begin
            outst_q <= outst_d;
            hold_q  <= hold_d;
        end
    end

    assign wb.o_wb_stall = stall;
    assign wb.o_wb_ack   = out_valid && (out_code == RESP_ACK);
    assign wb.o_wb_err   = out_valid && (out_code == RESP_ERR);
    assign wb.o_wb_data  = hold_d;

endmodule
